// File: rtl/dcache_if.sv
// Datapath-side request/response and word-wide memory port of the data cache.
// slave = cache end, master = datapath/memory end.
interface dcache_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic        datomic;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  modport slave (
    input  dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, halt, dwait, dload,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
  modport master (
    output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, halt, dwait, dload,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache.sv
// Direct-mapped write-back dcache, 2-word blocks; LL/SC link register under DCACHE_LLSC_EN.
// Hits answer in the same cycle; misses stall the requester until the memory port drops dwait.
module dcache #(
  parameter int NSETS = 16
) (
  input logic     CLK,
  input logic     nRST,
  dcache_if.slave dif
);
  localparam int IW = $clog2(NSETS);
  localparam int TW = 29 - IW;

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] WB0       = 4'd1;
  localparam logic [3:0] WB1       = 4'd2;
  localparam logic [3:0] FETCH0    = 4'd3;
  localparam logic [3:0] FETCH1    = 4'd4;
  localparam logic [3:0] FLUSH_CHK = 4'd5;
  localparam logic [3:0] FLUSH0    = 4'd6;
  localparam logic [3:0] FLUSH1    = 4'd7;
  localparam logic [3:0] FLUSHED   = 4'd8;

  logic [3:0]    r_state;
  logic [IW-1:0] r_cnt;
  logic [NSETS-1:0] r_valid, r_dirty;
  logic [TW-1:0] r_tag [NSETS];
  logic [31:0]   r_w0  [NSETS];
  logic [31:0]   r_w1  [NSETS];

  logic [TW-1:0] w_tag;
  logic [IW-1:0] w_idx, w_sidx;
  logic          w_off, w_req, w_hit, w_sc_fail, w_served, w_store, w_flush, w_last;
  logic          w_unused;

  assign w_tag    = dif.dmemaddr[31:3+IW];
  assign w_idx    = dif.dmemaddr[2+IW:3];
  assign w_off    = dif.dmemaddr[2];
  assign w_unused = ^dif.dmemaddr[1:0];
  assign w_req    = dif.dmemREN | dif.dmemWEN;
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_flush  = (r_state == FLUSH_CHK) || (r_state == FLUSH0) || (r_state == FLUSH1);
  assign w_sidx   = w_flush ? r_cnt : w_idx;
  assign w_last   = (r_cnt == IW'(NSETS - 1));

`ifdef DCACHE_LLSC_EN
  logic        r_link_vld;
  logic [29:0] r_link_addr;
  logic        w_link_match, w_ll;

  assign w_link_match = r_link_vld && (r_link_addr == dif.dmemaddr[31:2]);
  assign w_ll         = dif.dmemREN & ~dif.dmemWEN & dif.datomic;
  // A failing SC is answered at once without touching the array or memory.
  assign w_sc_fail    = dif.dmemWEN & dif.datomic & ~w_link_match;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_link_vld  <= 1'b0;
      r_link_addr <= '0;
    end else if (r_state == IDLE && w_req && w_hit) begin
      if (w_ll) begin
        r_link_vld  <= 1'b1;
        r_link_addr <= dif.dmemaddr[31:2];
      end else if (w_store && w_link_match) begin
        r_link_vld  <= 1'b0;
      end
    end
  end
`else
  assign w_sc_fail = 1'b0;
`endif

  assign w_served = (r_state == IDLE) && w_req && (w_hit || w_sc_fail);
  assign w_store  = (r_state == IDLE) && dif.dmemWEN && w_hit && !w_sc_fail;

  always_comb begin
    dif.dhit     = w_served;
    dif.dmemload = 32'h0;
    dif.flushed  = (r_state == FLUSHED);
    dif.dREN     = 1'b0;
    dif.dWEN     = 1'b0;
    dif.daddr    = 32'h0;
    dif.dstore   = 32'h0;
    if (w_served)
      dif.dmemload = dif.dmemWEN ? {31'h0, dif.datomic & ~w_sc_fail}
                                 : (w_off ? r_w1[w_idx] : r_w0[w_idx]);
    case (r_state)
      WB0, FLUSH0: begin
        dif.dWEN   = 1'b1;
        dif.daddr  = {r_tag[w_sidx], w_sidx, 1'b0, 2'b00};
        dif.dstore = r_w0[w_sidx];
      end
      WB1, FLUSH1: begin
        dif.dWEN   = 1'b1;
        dif.daddr  = {r_tag[w_sidx], w_sidx, 1'b1, 2'b00};
        dif.dstore = r_w1[w_sidx];
      end
      FETCH0: begin
        dif.dREN  = 1'b1;
        dif.daddr = {w_tag, w_idx, 1'b0, 2'b00};
      end
      FETCH1: begin
        dif.dREN  = 1'b1;
        dif.daddr = {w_tag, w_idx, 1'b1, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (w_hit || w_sc_fail) begin
              if (w_store) r_dirty[w_idx] <= 1'b1;
            end else begin
              r_state <= r_dirty[w_idx] ? WB0 : FETCH0;
            end
          end else if (dif.halt) begin
            r_state <= FLUSH_CHK;
            r_cnt   <= '0;
          end
        end
        WB0:    if (!dif.dwait) r_state <= WB1;
        WB1:    if (!dif.dwait) r_state <= FETCH0;
        FETCH0: if (!dif.dwait) r_state <= FETCH1;
        FETCH1: if (!dif.dwait) begin
          r_valid[w_idx] <= 1'b1;
          r_dirty[w_idx] <= 1'b0;
          r_state        <= IDLE;
        end
        FLUSH_CHK: begin
          if (r_dirty[r_cnt]) r_state <= FLUSH0;
          else if (w_last)    r_state <= FLUSHED;
          else                r_cnt   <= r_cnt + 1'b1;
        end
        FLUSH0: if (!dif.dwait) r_state <= FLUSH1;
        FLUSH1: if (!dif.dwait) begin
          r_dirty[r_cnt] <= 1'b0;
          if (w_last) begin
            r_state <= FLUSHED;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= FLUSH_CHK;
          end
        end
        FLUSHED: r_state <= FLUSHED;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Array contents need no reset: valid gates every use.
  always_ff @(posedge CLK) begin
    if (w_store) begin
      if (w_off) r_w1[w_idx] <= dif.dmemstore;
      else       r_w0[w_idx] <= dif.dmemstore;
    end
    if (r_state == FETCH0 && !dif.dwait) r_w0[w_idx] <= dif.dload;
    if (r_state == FETCH1 && !dif.dwait) begin
      r_w1[w_idx]  <= dif.dload;
      r_tag[w_idx] <= w_tag;
    end
  end
endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios plus random traffic against a block-level model.
module tb_dcache;
  localparam int NSETS = 16;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  dcache_if dif();
  dcache #(.NSETS(NSETS)) dut (.CLK(CLK), .nRST(nRST), .dif(dif));

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  int checks = 0;
  int failures = 0;
  xfer_t log_q[$];
  xfer_t exp_q[$];
  logic [31:0] mem    [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];
  int busy_pct = 0;
  int stall_cnt = 0;
  bit block_w1 = 1'b0;

  // model: which block each set holds, whether it is dirty, and the LL link
  bit          res_vld   [NSETS];
  bit          res_dirty [NSETS];
  logic [31:0] res_blk   [NSETS];
  bit          link_vld;
  logic [29:0] link_w;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] sh_rd(input logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // memory responder: random busy cycles, logs each completed transfer
  initial begin
    bit busy;
    dif.dwait = 1'b1;
    dif.dload = 32'h0;
    forever begin
      @(negedge CLK);
      if (nRST && (dif.dREN || dif.dWEN)) begin
        busy = ($urandom_range(0, 99) < busy_pct);
        if (stall_cnt > 0) begin
          busy = 1'b1;
          stall_cnt--;
        end
        if (block_w1 && dif.dWEN && dif.daddr[2]) busy = 1'b1;
        dif.dwait = busy;
        dif.dload = dif.dREN ? mem_rd(dif.daddr) : 32'h0;
        if (!busy) begin
          if (dif.dWEN) mem[dif.daddr] = dif.dstore;
          log_q.push_back('{dif.dWEN, dif.daddr, dif.dstore});
        end
      end else begin
        dif.dwait = 1'b1;
      end
    end
  end

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++) begin
      res_vld[s] = 1'b0;
      res_dirty[s] = 1'b0;
      res_blk[s] = 32'h0;
    end
    link_vld = 1'b0;
    link_w = 30'h0;
    shadow = mem;
  endtask

  task automatic model_op(input bit ren, input bit wen, input bit at, input logic [31:0] addr,
                          input logic [31:0] data, output bit chk_load, output logic [31:0] exp_load);
    logic [31:0] blk;
    logic [31:0] wa;
    int set;
    exp_q.delete();
    chk_load = 1'b0;
    exp_load = 32'h0;
`ifdef DCACHE_LLSC_EN
    if (wen && at && !(link_vld && link_w == addr[31:2])) begin
      chk_load = 1'b1;
      return;
    end
`endif
    blk = addr >> 3;
    set = int'(blk % NSETS);
    wa  = {addr[31:2], 2'b00};
    if (!(res_vld[set] && res_blk[set] == blk)) begin
      if (res_vld[set] && res_dirty[set]) begin
        exp_q.push_back('{1'b1, res_blk[set] << 3, sh_rd(res_blk[set] << 3)});
        exp_q.push_back('{1'b1, (res_blk[set] << 3) + 4, sh_rd((res_blk[set] << 3) + 4)});
      end
      exp_q.push_back('{1'b0, blk << 3, 32'h0});
      exp_q.push_back('{1'b0, (blk << 3) + 4, 32'h0});
      res_vld[set] = 1'b1;
      res_blk[set] = blk;
      res_dirty[set] = 1'b0;
    end
    if (wen) begin
      shadow[wa] = data;
      res_dirty[set] = 1'b1;
      if (at) begin
        chk_load = 1'b1;
        exp_load = 32'h1;
      end
      if (link_vld && link_w == addr[31:2]) link_vld = 1'b0;
    end else begin
      chk_load = 1'b1;
      exp_load = sh_rd(wa);
      if (ren && at) begin
        link_vld = 1'b1;
        link_w = addr[31:2];
      end
    end
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, " xfer_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk({tag, " xfer_wr"}, 32'(log_q[i].wr), 32'(exp_q[i].wr));
      chk({tag, " xfer_addr"}, log_q[i].addr, exp_q[i].addr);
      if (exp_q[i].wr) chk({tag, " xfer_data"}, log_q[i].data, exp_q[i].data);
    end
  endtask

  // called at posedge+1; returns at posedge+1 after the hit edge
  task automatic do_op(input bit ren, input bit wen, input bit at, input logic [31:0] addr,
                       input logic [31:0] data, input int stall, input string tag);
    bit cl;
    bit got;
    logic [31:0] el;
    logic [31:0] ld;
    int cyc;
    int ntr;
    model_op(ren, wen, at, addr, data, cl, el);
    ntr = exp_q.size();
    log_q.delete();
    dif.dmemREN = ren;
    dif.dmemWEN = wen;
    dif.datomic = at;
    dif.dmemaddr = addr;
    dif.dmemstore = data;
    stall_cnt = stall;
    for (int i = 0; i < stall; i++) begin
      @(posedge CLK);
      #1;
      chk({tag, " stall_dREN"}, 32'(dif.dREN), 32'h1);
      chk({tag, " stall_daddr"}, dif.daddr, exp_q[0].addr);
      chk({tag, " stall_dhit"}, 32'(dif.dhit), 32'h0);
    end
    cyc = 0;
    got = 1'b0;
    ld = 32'h0;
    while (!got && cyc < 500) begin
      @(negedge CLK);
      if (dif.dhit) begin
        got = 1'b1;
        ld = dif.dmemload;
        chk({tag, " hit_idle"}, 32'(dif.dREN | dif.dWEN), 32'h0);
      end else begin
        cyc++;
      end
      @(posedge CLK);
      #1;
    end
    dif.dmemREN = 1'b0;
    dif.dmemWEN = 1'b0;
    dif.datomic = 1'b0;
    chk({tag, " dhit"}, 32'(got), 32'h1);
    if (cl) chk({tag, " dmemload"}, ld, el);
    cmp_log(tag);
    if (busy_pct == 0 && stall == 0)
      chk({tag, " latency"}, 32'(cyc), (ntr == 0) ? 32'h0 : 32'(ntr + 1));
  endtask

  task automatic do_flush(input string tag);
    bit got;
    int cyc;
    exp_q.delete();
    for (int s = 0; s < NSETS; s++) begin
      if (res_vld[s] && res_dirty[s]) begin
        exp_q.push_back('{1'b1, res_blk[s] << 3, sh_rd(res_blk[s] << 3)});
        exp_q.push_back('{1'b1, (res_blk[s] << 3) + 4, sh_rd((res_blk[s] << 3) + 4)});
        res_dirty[s] = 1'b0;
      end
    end
    log_q.delete();
    dif.halt = 1'b1;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 5000) begin
      @(negedge CLK);
      if (dif.flushed) got = 1'b1;
      cyc++;
    end
    chk({tag, " flushed"}, 32'(got), 32'h1);
    cmp_log(tag);
    dif.dmemREN = 1'b1;
    dif.dmemaddr = 32'h0000_0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk({tag, " flushed_held"}, 32'(dif.flushed), 32'h1);
      chk({tag, " flushed_nohit"}, 32'(dif.dhit), 32'h0);
      chk({tag, " flushed_quiet"}, 32'(dif.dREN | dif.dWEN), 32'h0);
    end
    dif.dmemREN = 1'b0;
    foreach (shadow[a]) chk({tag, " mem_image"}, mem_rd(a), shadow[a]);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    dif.halt = 1'b0;
    dif.dmemREN = 1'b0;
    dif.dmemWEN = 1'b0;
    dif.datomic = 1'b0;
    stall_cnt = 0;
    block_w1 = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int r;
    bit reached;
    logic [31:0] a;
    nRST = 1'b0;
    dif.dmemREN = 1'b0;
    dif.dmemWEN = 1'b0;
    dif.datomic = 1'b0;
    dif.dmemaddr = 32'h0;
    dif.dmemstore = 32'h0;
    dif.halt = 1'b0;
    mem[32'h100] = 32'hAAAA_0000;
    mem[32'h104] = 32'hAAAA_0001;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst dhit", 32'(dif.dhit), 32'h0);
    chk("rst dREN", 32'(dif.dREN), 32'h0);
    chk("rst dWEN", 32'(dif.dWEN), 32'h0);
    chk("rst flushed", 32'(dif.flushed), 32'h0);
    chk("rst daddr", dif.daddr, 32'h0);
    chk("rst dstore", dif.dstore, 32'h0);
    chk("rst dmemload", dif.dmemload, 32'h0);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    do_op(1, 0, 0, 32'h100, 32'h0, 0, "cold_load");
    do_op(1, 0, 0, 32'h100, 32'h0, 0, "repeat_load");
    do_op(0, 1, 0, 32'h100, 32'hDEAD, 0, "store_hit");
    do_op(1, 0, 0, 32'h180, 32'h0, 0, "dirty_evict");
    do_op(1, 0, 0, 32'h300, 32'h0, 5, "stall_fetch");
    do_op(1, 0, 1, 32'h200, 32'h0, 0, "ll1");
    do_op(0, 1, 1, 32'h200, 32'h7, 0, "sc1");
    do_op(1, 0, 0, 32'h200, 32'h0, 0, "ld_after_sc");
    do_op(1, 0, 1, 32'h200, 32'h0, 0, "ll2");
    do_op(0, 1, 0, 32'h200, 32'h9, 0, "sw_linked");
    do_op(0, 1, 1, 32'h200, 32'h5, 0, "sc2");
    do_op(1, 0, 0, 32'h200, 32'h0, 0, "ld_after_sc2");

    busy_pct = 30;
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 9));
      a = 32'h1000 | ($urandom_range(0, 3) << 7) | ($urandom_range(0, NSETS - 1) << 3)
                   | ($urandom_range(0, 1) << 2);
      if (r < 5)       do_op(1, 0, 0, a, 32'h0, 0, "rnd_load");
      else if (r < 8)  do_op(0, 1, 0, a, $urandom, 0, "rnd_store");
      else if (r == 8) do_op(1, 0, 1, a, 32'h0, 0, "rnd_ll");
      else             do_op(0, 1, 1, a, $urandom, 0, "rnd_sc");
    end
    do_flush("flush_rand");

    do_reset();
    busy_pct = 0;
    do_op(0, 1, 0, 32'h1000, 32'h1111_0000, 0, "dirty_set0");
    do_op(0, 1, 0, 32'h1028, 32'h5555_0005, 0, "dirty_set5");
    do_flush("flush_0_5");

    do_reset();
    do_op(0, 1, 0, 32'h1000, 32'hBEEF_0001, 0, "pre_wb_store");
    block_w1 = 1'b1;
    dif.dmemREN = 1'b1;
    dif.dmemaddr = 32'h1080;
    reached = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      @(posedge CLK);
      #1;
      if (dif.dWEN && dif.daddr == 32'h1004) reached = 1'b1;
    end
    chk("wb1_reached", 32'(reached), 32'h1);
    nRST = 1'b0;
    #1;
    chk("rst_mid_dWEN", 32'(dif.dWEN), 32'h0);
    chk("rst_mid_dREN", 32'(dif.dREN), 32'h0);
    do_reset();
    do_op(1, 0, 0, 32'h1000, 32'h0, 0, "post_rst_load");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back data cache that is the responder end of the datapath–cache interface: it accepts load, store and atomic (LL/SC) requests from the pipelined datapath's memory stage and answers with a hit strobe and load data. Misses and dirty evictions go out on a word-wide memory port to the bus/arbiter. On processor halt it writes back every dirty block and then raises `flushed`.

## Interface
- NSETS, 16, number of sets; power of two, ≥2.
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- dmemREN  in  1  datapath load request.
- dmemWEN  in  1  datapath store request.
- datomic  in  1  request is LL (with REN) or SC (with WEN).
- dmemaddr  in  32  byte address; [1:0] ignored.
- dmemstore  in  32  store data.
- halt  in  1  processor halted; sticky once high.
- dhit  out  1  request served this cycle.
- dmemload  out  32  load data, or SC result (1 success, 0 fail).
- flushed  out  1  flush complete; held until reset.
- dREN  out  1  memory read request.
- dWEN  out  1  memory write request.
- daddr  out  32  memory word address.
- dstore  out  32  memory write data.
- dwait  in  1  memory busy; transfer completes in a cycle with dwait=0.
- dload  in  32  memory read data.

## Operation
- Block = 2 words. Address split: [2] word offset, [2+log2(NSETS):3] index, remaining upper bits tag. Per set: valid, dirty, tag, word0, word1.
- States: IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH_CHK, FLUSH0, FLUSH1, FLUSHED.
- IDLE, request present, valid & tag match: dhit=1 combinationally. Read: dmemload = selected word. Write: word updated, dirty set at the clock edge.
- IDLE, miss: dirty victim -> WB0; else -> FETCH0.
- WB0/WB1: dWEN=1, daddr = {victim tag, index, 0/1, 2'b00}, dstore = victim word0/1; advance on dwait=0. WB1 -> FETCH0.
- FETCH0/FETCH1: dREN=1, daddr = {req tag, index, 0/1, 2'b00}; capture dload on dwait=0. FETCH1 completion: valid=1, dirty=0, tag written -> IDLE; request is re-evaluated there and hits.
- dmemREN and dmemWEN both high: treated as write.
- halt high in IDLE with no request: -> FLUSH_CHK with set counter = 0. A request in progress finishes first.
- FLUSH_CHK: set dirty -> FLUSH0; else counter+1. After set NSETS-1 -> FLUSHED.
- FLUSH0/FLUSH1: write both words as in WB0/WB1; after FLUSH1 clear dirty, counter+1, -> FLUSH_CHK (or FLUSHED after the last set).
- FLUSHED: flushed=1, dhit=0, no memory traffic until reset.

## Timing
- Reset: all valid/dirty = 0, link invalid, state IDLE, flush counter 0. Outputs dhit, dREN, dWEN, flushed = 0; daddr, dstore, dmemload = 0.
- Hit latency 0 cycles (dhit same cycle as request). Clean miss: 2 memory transfers + 1 cycle. Dirty miss: 4 transfers + 1 cycle.
- dREN/dWEN, daddr, dstore held stable until the cycle with dwait=0. The next transfer is issued on the following cycle.
- dhit is never asserted outside IDLE. It is asserted for exactly one cycle per write and per SC, because the datapath drops the request after that hit.
- Reset mid-transfer: dREN/dWEN drop immediately (async). The partial block is discarded.

## Configuration
- DCACHE_LLSC_EN defined: link register (address + valid).
  - LL hit: loads data, link = address, link valid.
  - SC: if link valid and address matches, performs the store (miss handled as a normal write miss), dmemload = 1, and clears the link. Otherwise no store, dhit = 1 in IDLE immediately, dmemload = 0.
  - Any store hit to the linked word clears the link.
- DCACHE_LLSC_EN undefined: datomic ignored. LL behaves as a load; SC behaves as a store and returns dmemload = 1.

## Test plan
- Cold load 0x100, memory returns 0xAAAA0000/0xAAAA0001 -> dREN at 0x100 then 0x104, then dhit=1, dmemload=0xAAAA0000. Repeat load -> dhit same cycle, no dREN.
- Store 0xDEAD to 0x100, then load 0x100 + 16×8 (same index, new tag) -> WB0/WB1 write 0xDEAD@0x100 and the other word@0x104, then fetch new block.
- dwait held high 5 cycles during FETCH0 -> daddr/dREN stable for all 5 cycles, no dhit.
- LL 0x200, SC 0x200 val 7 -> dmemload=1, later load returns 7. LL 0x200, SW 0x200, SC 0x200 -> dmemload=0, value unchanged. Run with macro defined.
- Dirty sets 0 and 5, halt=1 -> exactly 4 dWEN transfers (sets 0 then 5), then flushed=1 held.
- Assert nRST=0 during WB1 -> dWEN=0 immediately. After release, load to the old address misses.
